// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the masked-AES wrapper logic and its benches:
//   - seq_state_t        : dual-run sequencer FSM states
//   - AES_MASK_LFSR_TAPS : Galois feedback taps for the mask LFSR
//   - AES_CORE_LATENCY   : cycles from core start to core done
//   - AES_FIPS_*         : FIPS-197 appendix C.1 AES-128 vector
//   - aes_lfsr_next()    : one Galois LFSR step
// ---------------------------------------------------------------------------
package aes_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH1 = 3'd1,
    WAIT1   = 3'd2,
    LAUNCH2 = 3'd3,
    WAIT2   = 3'd4,
    RESP    = 3'd5
  } seq_state_t;

  localparam logic [31:0] AES_MASK_LFSR_TAPS = 32'h8020_0003;
  localparam int          AES_CORE_LATENCY   = 267;

  localparam logic [127:0] AES_FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] AES_FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] AES_FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb70480b4c55a;

  // Right-shifting Galois step: the bit shifted out selects the tap XOR.
  function automatic logic [31:0] aes_lfsr_next(input logic [31:0] state);
    return state[0] ? ((state >> 1) ^ AES_MASK_LFSR_TAPS) : (state >> 1);
  endfunction

endpackage

// File: rtl/aes_mask_lfsr.sv
// ---------------------------------------------------------------------------
// aes_mask_lfsr
// 32-bit Galois LFSR that supplies mask words to the masked AES core.
// Advances every cycle; a seed load takes priority over the advance.
// A zero seed would lock the register at zero, so it loads 32'h1 instead.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   seed_load   : load seed this cycle
//   seed        : seed value
//   lfsr        : current LFSR state
// ---------------------------------------------------------------------------
module aes_mask_lfsr
  import aes_pkg::*;
#(
  parameter logic [31:0] LFSR_RESET = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [31:0] seed,
  output logic [31:0] lfsr
);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= LFSR_RESET;
    end else if (seed_load) begin
      lfsr <= (seed == 32'h0) ? 32'h1 : seed;
    end else begin
      lfsr <= aes_lfsr_next(lfsr);
    end
  end

endmodule

// File: rtl/aes_dual_run_sequencer.sv
// ---------------------------------------------------------------------------
// aes_dual_run_sequencer
// Runs each AES-128 job on the masked core twice with different mask bytes
// and releases the ciphertext only when both runs agree. A mismatch or a
// core timeout returns an all-zero ciphertext with rsp_fault set.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   req_valid/req_ready              : job request handshake
//   req_plaintext, req_key           : job data
//   seed_load, seed                  : mask LFSR reseed
//   core_start                       : one-cycle start pulse to the core
//   core_plaintext/core_key/core_mask: registered core inputs
//   core_busy, core_done             : core status
//   core_ciphertext                  : core result
//   rsp_valid/rsp_ready              : response handshake
//   rsp_ciphertext, rsp_fault        : response data (zero data on fault)
//   fault_count                      : saturating count of faulted jobs
// ---------------------------------------------------------------------------
module aes_dual_run_sequencer
  import aes_pkg::*;
#(
  parameter int          DUAL_RUN   = 1,
  parameter int          TIMEOUT    = 400,
  parameter logic [31:0] LFSR_RESET = 32'hACE1_2468
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [127:0] req_plaintext,
  input  logic [127:0] req_key,
  input  logic         seed_load,
  input  logic [31:0]  seed,
  output logic         core_start,
  output logic [127:0] core_plaintext,
  output logic [127:0] core_key,
  output logic [127:0] core_mask,
  input  logic         core_busy,
  input  logic         core_done,
  input  logic [127:0] core_ciphertext,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_ciphertext,
  output logic         rsp_fault,
  output logic [15:0]  fault_count
);

  // The timer reads 0 in the cycle core_start is visible, so the last
  // permitted WAIT cycle is TIMEOUT-1; RESP then begins TIMEOUT cycles
  // after the start pulse.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  seq_state_t   state_q, state_d;
  logic [31:0]  lfsr;
  logic [15:0]  timer_q;
  logic [127:0] ct1_q;
  logic [7:0]   m1_q;

  logic         accept;
  logic         launch;
  logic         in_wait;
  logic         timeout;
  logic         enter_resp;
  logic         rsp_hs;
  logic         resp_fault_d;
  logic [127:0] result_ct;
  logic [7:0]   mask_byte;
  logic [31:0]  mask_word;

  aes_mask_lfsr #(
    .LFSR_RESET (LFSR_RESET)
  ) u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed      (seed),
    .lfsr      (lfsr)
  );

  assign in_wait    = (state_q == WAIT1) || (state_q == WAIT2);
  assign timeout    = (timer_q >= TIMEOUT_LAST);
  assign rsp_hs     = rsp_valid && rsp_ready;
  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  // The second run must see a different mask byte from the first; on a
  // collision flip the LSB, which guarantees inequality.
  always_comb begin
    mask_byte = lfsr[7:0];
    if ((state_q == LAUNCH2) && (lfsr[7:0] == m1_q)) begin
      mask_byte = lfsr[7:0] ^ 8'h01;
    end
    mask_word = {lfsr[31:8], mask_byte};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    launch       = 1'b0;
    resp_fault_d = 1'b0;
    result_ct    = ct1_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept  = 1'b1;
          state_d = LAUNCH1;
        end
      end
      LAUNCH1, LAUNCH2: begin
        if (!core_busy) begin
          launch  = 1'b1;
          state_d = (state_q == LAUNCH1) ? WAIT1 : WAIT2;
        end
      end
      WAIT1: begin
        if (core_done) begin
          result_ct = core_ciphertext;
          state_d   = (DUAL_RUN != 0) ? LAUNCH2 : RESP;
        end else if (timeout) begin
          resp_fault_d = 1'b1;
          state_d      = RESP;
        end
      end
      WAIT2: begin
        if (core_done) begin
          resp_fault_d = (core_ciphertext != ct1_q);
          state_d      = RESP;
        end else if (timeout) begin
          resp_fault_d = 1'b1;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the wide data registers are reset as well, because the core
  // inputs and the response bus must read zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      core_start     <= 1'b0;
      core_plaintext <= '0;
      core_key       <= '0;
      core_mask      <= '0;
      ct1_q          <= '0;
      m1_q           <= '0;
      timer_q        <= '0;
      rsp_ciphertext <= '0;
      rsp_fault      <= 1'b0;
      fault_count    <= '0;
    end else begin
      // Registered from the next state so req_ready stays low in the
      // handshake cycle and rsp_valid follows RESP exactly.
      req_ready  <= (state_d == IDLE);
      rsp_valid  <= (state_d == RESP);
      core_start <= launch;

      if (accept) begin
        core_plaintext <= req_plaintext;
        core_key       <= req_key;
      end

      if (launch) begin
        core_mask <= {4{mask_word}};
        timer_q   <= '0;
        if (state_q == LAUNCH1) begin
          m1_q <= mask_byte;
        end
      end else if (in_wait && (timer_q != 16'hFFFF)) begin
        timer_q <= timer_q + 16'd1;
      end

      if ((state_q == WAIT1) && core_done) begin
        ct1_q <= core_ciphertext;
      end

      if (enter_resp) begin
        rsp_fault      <= resp_fault_d;
        rsp_ciphertext <= resp_fault_d ? '0 : result_ct;
      end else if (rsp_hs) begin
        rsp_fault      <= 1'b0;
        rsp_ciphertext <= '0;
      end

      if (rsp_hs && rsp_fault && (fault_count != 16'hFFFF)) begin
        fault_count <= fault_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_dual_run_sequencer.sv
// ---------------------------------------------------------------------------
// tb_aes_dual_run_sequencer
// Drives jobs into the sequencer around a behavioural stand-in for the
// masked AES core. Expected responses go into a queue when each job is
// issued; a monitor pops and compares on every response handshake.
// ---------------------------------------------------------------------------
module tb_aes_dual_run_sequencer;
  import aes_pkg::*;

  localparam int TIMEOUT = 400;

  typedef struct {
    logic [127:0] ct;
    logic         fault;
    int           starts;
    int           mask_mode;  // 0 none, 1 bytes differ, 2 zero seed, 3 collision
    bit           chk_lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [127:0] req_plaintext;
  logic [127:0] req_key;
  logic         seed_load;
  logic [31:0]  seed;
  logic         core_start;
  logic [127:0] core_plaintext;
  logic [127:0] core_key;
  logic [127:0] core_mask;
  logic         core_busy;
  logic         core_done;
  logic [127:0] core_ciphertext;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [127:0] rsp_ciphertext;
  logic         rsp_fault;
  logic [15:0]  fault_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  exp_t sb[$];

  // core stand-in state
  bit           never_done  = 1'b0;
  bit           inject_run1 = 1'b0;
  int           seed_mode   = 0;
  int           n_start     = 0;
  int           base        = 0;
  int           stub_run    = 0;
  int           cnt         = 0;
  bit           counting    = 1'b0;
  int           last_start_cyc = 0;
  logic [127:0] mask_seen [2];
  logic [127:0] stub_pt, stub_key;
  logic [127:0] cur_pt, cur_key;

  // monitor state
  int           exp_fc = 0;
  bit           fc_pending = 1'b0;
  bit           prev_valid = 1'b0;
  bit           unstable = 1'b0;
  int           rise_cyc = 0;
  int           last_hs_cyc = 0;
  int           accept_cyc = 0;
  logic [127:0] cap_ct;
  logic         cap_f;

  aes_dual_run_sequencer #(
    .DUAL_RUN   (1),
    .TIMEOUT    (TIMEOUT),
    .LFSR_RESET (32'hACE1_2468)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_plaintext   (req_plaintext),
    .req_key         (req_key),
    .seed_load       (seed_load),
    .seed            (seed),
    .core_start      (core_start),
    .core_plaintext  (core_plaintext),
    .core_key        (core_key),
    .core_mask       (core_mask),
    .core_busy       (core_busy),
    .core_done       (core_done),
    .core_ciphertext (core_ciphertext),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_ciphertext  (rsp_ciphertext),
    .rsp_fault       (rsp_fault),
    .fault_count     (fault_count)
  );

  always #5 clk = ~clk;
  always_ff @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Core result: the real FIPS-197 answer for the reference vector,
  // otherwise an arbitrary but deterministic mix of plaintext and key.
  function automatic logic [127:0] core_model(input logic [127:0] pt, input logic [127:0] key);
    if (pt == AES_FIPS_PT && key == AES_FIPS_KEY) return AES_FIPS_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'hC3C3_0F0F_5A5A_A5A5_1234_5678_9ABC_DEF0;
  endfunction

  // Core stand-in: done fires AES_CORE_LATENCY cycles after the start pulse.
  // It is also the only driver of seed_load so reseeding can land exactly
  // in the cycle the sequencer moves into its second launch.
  initial begin
    core_busy = 1'b0; core_done = 1'b0; core_ciphertext = '0;
    seed_load = 1'b0; seed = '0;
    mask_seen[0] = '0; mask_seen[1] = '0;
    forever begin
      @(negedge clk);
      core_done = 1'b0;
      seed_load = 1'b0;
      if (counting) begin
        cnt++;
        if (cnt == AES_CORE_LATENCY) begin
          counting  = 1'b0;
          core_busy = 1'b0;
          core_done = 1'b1;
          core_ciphertext = core_model(stub_pt, stub_key) ^
                            ((inject_run1 && stub_run == 0) ? 128'h1 : 128'h0);
          if (stub_run == 0 && seed_mode == 1) begin
            seed_load = 1'b1; seed = 32'h0;
          end else if (stub_run == 0 && seed_mode == 2) begin
            seed_load = 1'b1; seed = {24'h5A5A5A, mask_seen[0][7:0]};
          end
        end
      end
      if (core_start) begin
        stub_run = n_start - base;
        n_start++;
        last_start_cyc = cyc;
        if (stub_run < 2) mask_seen[stub_run] = core_mask;
        check("core_mask_replicated", core_mask, {4{core_mask[31:0]}});
        check("core_plaintext", core_plaintext, cur_pt);
        check("core_key", core_key, cur_key);
        stub_pt  = core_plaintext;
        stub_key = core_key;
        if (!never_done) begin
          counting  = 1'b1;
          cnt       = 0;
          core_busy = 1'b1;
        end
      end
    end
  end

  // Response monitor / scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        base       = n_start;
        exp_fc     = 0;
        fc_pending = 1'b0;
        prev_valid = 1'b0;
      end else begin
        if (fc_pending) begin
          check("fault_count", 128'(fault_count), 128'(exp_fc));
          fc_pending = 1'b0;
        end
        if (rsp_valid && !prev_valid) begin
          rise_cyc = cyc;
          cap_ct   = rsp_ciphertext;
          cap_f    = rsp_fault;
          unstable = 1'b0;
          check("rsp_expected", 128'(sb.size() != 0), 128'(1));
        end else if (rsp_valid && (rsp_ciphertext !== cap_ct || rsp_fault !== cap_f)) begin
          unstable = 1'b1;
        end
        if (rsp_valid && rsp_ready && sb.size() != 0) begin
          e = sb.pop_front();
          check("rsp_ciphertext", rsp_ciphertext, e.ct);
          check("rsp_fault", 128'(rsp_fault), 128'(e.fault));
          check("core_start_count", 128'(n_start - base), 128'(e.starts));
          check("rsp_stable", 128'(unstable), 128'(0));
          if (e.mask_mode == 1)
            check("mask_bytes_differ", 128'(mask_seen[0][7:0] != mask_seen[1][7:0]), 128'(1));
          if (e.mask_mode == 2)
            check("mask2_after_zero_seed", mask_seen[1],
                  {4{(mask_seen[0][7:0] == 8'h01) ? 32'h0 : 32'h1}});
          if (e.mask_mode == 3)
            check("mask2_collision", mask_seen[1],
                  {4{24'h5A5A5A, mask_seen[0][7:0] ^ 8'h01}});
          if (e.chk_lat)
            check("timeout_latency_400_402",
                  128'((rise_cyc - last_start_cyc) >= TIMEOUT &&
                       (rise_cyc - last_start_cyc) <= TIMEOUT + 2), 128'(1));
          if (e.fault) exp_fc++;
          fc_pending  = 1'b1;
          last_hs_cyc = cyc;
          base        = n_start;
        end
        prev_valid = rsp_valid;
      end
    end
  end

  task automatic push(input logic [127:0] ct, input logic f, input int starts,
                      input int mm, input bit lat);
    exp_t e;
    e.ct = ct; e.fault = f; e.starts = starts; e.mask_mode = mm; e.chk_lat = lat;
    sb.push_back(e);
  endtask

  task automatic send_job(input logic [127:0] pt, input logic [127:0] key);
    int b;
    cur_pt = pt; cur_key = key;
    req_plaintext = pt; req_key = key; req_valid = 1'b1;
    b = 0;
    while (!req_ready && b < 2000) begin
      @(posedge clk); #1; b++;
    end
    check("req_accepted_in_time", 128'(req_ready), 128'(1));
    accept_cyc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int b;
    b = 0;
    while ((sb.size() != 0 || rsp_valid) && b < 3000) begin
      @(posedge clk); #1; b++;
    end
    check({name, "_drained"}, 128'(sb.size()), 128'(0));
    repeat (2) @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] PT_A  = 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
  localparam logic [127:0] KEY_A = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
  localparam logic [127:0] PT_B  = 128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [127:0] KEY_B = 128'hDEADBEEF0123456789ABCDEFFEEDC0DE;

  initial begin
    int b, bad, seen, n0;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_plaintext = '0; req_key = '0; cur_pt = '0; cur_key = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", 128'(req_ready), 128'(0));
    check("reset_rsp_valid", 128'(rsp_valid), 128'(0));
    check("reset_rsp_fault", 128'(rsp_fault), 128'(0));
    check("reset_core_start", 128'(core_start), 128'(0));
    check("reset_rsp_ciphertext", rsp_ciphertext, 128'h0);
    check("reset_core_data", core_plaintext | core_key | core_mask, 128'h0);
    check("reset_fault_count", 128'(fault_count), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Normal dual run on the FIPS-197 vector.
    push(AES_FIPS_CT, 1'b0, 2, 1, 1'b0);
    send_job(AES_FIPS_PT, AES_FIPS_KEY);
    wait_drain("normal");

    // Corrupted first run: mismatch must be flagged with zeroed data.
    inject_run1 = 1'b1;
    push(128'h0, 1'b1, 2, 0, 1'b0);
    send_job(AES_FIPS_PT, AES_FIPS_KEY);
    wait_drain("fault_inject");
    inject_run1 = 1'b0;

    // Core never finishes: timeout after TIMEOUT cycles, single start.
    never_done = 1'b1;
    push(128'h0, 1'b1, 1, 0, 1'b1);
    send_job(AES_FIPS_PT, AES_FIPS_KEY);
    wait_drain("timeout");
    never_done = 1'b0;

    // Zero seed loaded just before the second launch.
    seed_mode = 1;
    push(AES_FIPS_CT, 1'b0, 2, 2, 1'b0);
    send_job(AES_FIPS_PT, AES_FIPS_KEY);
    wait_drain("zero_seed");

    // Seed chosen so the second mask byte collides with the first.
    seed_mode = 2;
    push(core_model(PT_B, KEY_A), 1'b0, 2, 3, 1'b0);
    send_job(PT_B, KEY_A);
    wait_drain("collision");
    seed_mode = 0;

    // Backpressure: response held 50 cycles while a second job waits.
    rsp_ready = 1'b0;
    push(core_model(PT_A, KEY_A), 1'b0, 2, 1, 1'b0);
    send_job(PT_A, KEY_A);
    b = 0;
    while (!rsp_valid && b < 2000) begin
      @(posedge clk); #1; b++;
    end
    check("bp_rsp_valid", 128'(rsp_valid), 128'(1));
    req_plaintext = PT_B; req_key = KEY_B; req_valid = 1'b1;
    bad = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (req_ready || !rsp_valid) bad++;
    end
    check("bp_req_ready_low_rsp_held", 128'(bad), 128'(0));
    push(core_model(PT_B, KEY_B), 1'b0, 2, 1, 1'b0);
    rsp_ready = 1'b1;
    send_job(PT_B, KEY_B);
    check("bp_second_job_after_handshake", 128'(accept_cyc > last_hs_cyc), 128'(1));
    wait_drain("backpressure");

    // Reset during WAIT1: everything clears, the late done is ignored.
    n0 = n_start;
    send_job(AES_FIPS_PT, AES_FIPS_KEY);
    b = 0;
    while (n_start == n0 && b < 200) begin
      @(posedge clk); #1; b++;
    end
    check("midreset_job_started", 128'(n_start != n0), 128'(1));
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_req_ready", 128'(req_ready), 128'(0));
    check("midreset_rsp_valid", 128'(rsp_valid), 128'(0));
    check("midreset_core_start", 128'(core_start), 128'(0));
    check("midreset_core_data", core_plaintext | core_key | core_mask, 128'h0);
    check("midreset_fault_count", 128'(fault_count), 128'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (400) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    check("midreset_no_response", 128'(seen), 128'(0));

    // Recovery job after the abandoned one.
    push(AES_FIPS_CT, 1'b0, 2, 1, 1'b0);
    send_job(AES_FIPS_PT, AES_FIPS_KEY);
    wait_drain("recovery");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
